l2_bus_arbiter: RTL and testbench

L2_BUS_ARBITER -- requirements
Module: l2_bus_arbiter

---
 rtl/l2_arb_pkg.sv | 20 ++
 rtl/l2_bus_arbiter_if.sv | 32 +++
 rtl/l2_rr_pick.sv | 32 +++
 rtl/l2_bus_arbiter.sv | 101 ++++++++++
 tb/tb_l2_bus_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared FSM states, sizing defaults and address split.
// No ports; imported by the arbiter, its pick logic and its bus interface.
package l2_arb_pkg;

   localparam int NUM_PORTS  = 2;
   localparam int BURST_LEN  = 8;
   localparam int LINE_OFF_W = 5;
   localparam int BEAT_W     = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BEAT  = 2'd2
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/l2_bus_arbiter_if.sv
// l2_bus_arbiter_if: miss-handler request side and L2 memory side bundle.
// master = requesters/L2 observer, slave = arbiter.
interface l2_bus_arbiter_if #(
   parameter int NUM_PORTS = l2_arb_pkg::NUM_PORTS
);

   logic [NUM_PORTS-1:0]          rd_req;
   logic [NUM_PORTS-1:0]          wr_req;
   logic [NUM_PORTS-1:0][31:0]    req_addr;
   logic [NUM_PORTS-1:0][31:0]    req_wr_data;
   logic [NUM_PORTS-1:0]          rd_granted;
   logic [NUM_PORTS-1:0]          wr_granted;
   logic [31:0]                   l2_mem_addr;
   logic                          l2_mem_rd_en;
   logic                          l2_mem_wr_en;
   logic [31:0]                   l2_mem_wr_data;
   logic [l2_arb_pkg::BEAT_W-1:0] beat_cnt;
   logic                          bus_busy;

   modport master (
      output rd_req, wr_req, req_addr, req_wr_data,
      input  rd_granted, wr_granted, l2_mem_addr, l2_mem_rd_en,
      input  l2_mem_wr_en, l2_mem_wr_data, beat_cnt, bus_busy
   );

   modport slave (
      input  rd_req, wr_req, req_addr, req_wr_data,
      output rd_granted, wr_granted, l2_mem_addr, l2_mem_rd_en,
      output l2_mem_wr_en, l2_mem_wr_data, beat_cnt, bus_busy
   );

endinterface

// File: rtl/l2_rr_pick.sv
// l2_rr_pick: combinational round-robin pick over a request vector.
// Ports: req, last (previous winner) -> gnt (one-hot), valid.
module l2_rr_pick #(
   parameter int  NUM_PORTS = l2_arb_pkg::NUM_PORTS,
   localparam int LW        = l2_arb_pkg::idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [LW-1:0]        last,
   output logic [NUM_PORTS-1:0] gnt,
   output logic                 valid
);

   int          tmp;
   logic [LW-1:0] idx;

   // Search starts just after the previous winner, so it has lowest
   // priority; a lone requester still wins.
   always_comb begin
      gnt = '0;
      tmp = 0;
      idx = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         tmp = int'(last) + i;
         if (tmp >= NUM_PORTS) tmp = tmp - NUM_PORTS;
         idx = LW'(tmp);
         if (req[idx] && gnt == '0) gnt[idx] = 1'b1;
      end
   end

   assign valid = |req;

endmodule

// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: round-robin arbiter of I/D miss handlers onto the L2.
// Ports: clk, rst_n (sync, active-low), bus (slave side of l2_bus_arbiter_if).
module l2_bus_arbiter #(
   parameter int NUM_PORTS = l2_arb_pkg::NUM_PORTS,
   parameter int BURST_LEN = l2_arb_pkg::BURST_LEN
) (
   input logic              clk,
   input logic              rst_n,
   l2_bus_arbiter_if.slave  bus
);

   import l2_arb_pkg::*;

   localparam int LW = idx_w(NUM_PORTS);

   arb_state_e           state_q, state_d;
   logic [LW-1:0]        win_q, last_q, pick_idx;
   logic [BEAT_W-1:0]    beat_q;
   logic [31:0]          addr_q, data_q;
   logic [NUM_PORTS-1:0] req_any, pick_oh;
   logic                 pick_vld, pick_wr, last_beat;

   assign req_any = bus.rd_req | bus.wr_req;

   l2_rr_pick #(
      .NUM_PORTS(NUM_PORTS)
   ) u_pick (
      .req  (req_any),
      .last (last_q),
      .gnt  (pick_oh),
      .valid(pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (pick_oh[i]) pick_idx = LW'(i);
   end

   assign pick_wr   = bus.wr_req[pick_idx];
   assign last_beat = beat_q == BEAT_W'(BURST_LEN - 1);

   // Outputs decode only registered state; address/data were captured
   // at grant time, so nothing combinational leaks from the requesters.
   always_comb begin
      state_d            = state_q;
      bus.rd_granted     = '0;
      bus.wr_granted     = '0;
      bus.l2_mem_addr    = '0;
      bus.l2_mem_rd_en   = 1'b0;
      bus.l2_mem_wr_en   = 1'b0;
      bus.l2_mem_wr_data = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) state_d = pick_wr ? WR_BEAT : RD_BURST;
         end
         RD_BURST: begin
            bus.rd_granted[win_q] = 1'b1;
            bus.l2_mem_rd_en      = 1'b1;
            bus.l2_mem_addr       =
               {addr_q[31:LINE_OFF_W], beat_q, 2'b00};
            // Dropped request aborts; either way IDLE gives turnaround.
            if (!bus.rd_req[win_q] || last_beat) state_d = IDLE;
         end
         WR_BEAT: begin
            bus.wr_granted[win_q] = 1'b1;
            bus.l2_mem_wr_en      = 1'b1;
            bus.l2_mem_addr       = addr_q;
            bus.l2_mem_wr_data    = data_q;
            state_d               = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         win_q   <= '0;
         last_q  <= LW'(NUM_PORTS - 1);
         beat_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_vld) begin
            win_q  <= pick_idx;
            last_q <= pick_idx;
            addr_q <= bus.req_addr[pick_idx];
            data_q <= bus.req_wr_data[pick_idx];
            beat_q <= '0;
         end else if (state_q == RD_BURST) begin
            beat_q <= (state_d == IDLE) ? '0 : beat_q + 1'b1;
         end
      end
   end

   assign bus.beat_cnt = beat_q;
   assign bus.bus_busy = state_q != IDLE;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb_l2_bus_arbiter: directed scenarios plus random traffic for l2_bus_arbiter.
// Random traffic is predicted by a transaction-level model kept here.
module tb_l2_bus_arbiter;

   localparam int NP       = 2;
   localparam int PW       = 1;
   localparam int BL       = 8;
   localparam int WAIT_MAX = 2 * (BL + 1) + 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   l2_bus_arbiter_if #(.NUM_PORTS(NP)) bus ();

   l2_bus_arbiter #(
      .NUM_PORTS(NP),
      .BURST_LEN(BL)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [73:0] outv();
      return {bus.rd_granted, bus.wr_granted, bus.l2_mem_rd_en,
              bus.l2_mem_wr_en, bus.l2_mem_addr, bus.l2_mem_wr_data,
              bus.beat_cnt, bus.bus_busy};
   endfunction

   function automatic logic [73:0] mk(
      input logic [1:0] rg, input logic [1:0] wg,
      input logic re, input logic we,
      input logic [31:0] a, input logic [31:0] d,
      input logic [2:0] b, input logic busy);
      return {rg, wg, re, we, a, d, b, busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.rd_req = '0;
      bus.wr_req = '0;
      bus.req_addr = '0;
      bus.req_wr_data = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if (outv() !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h exp 0", outv());
      end
      tick();
      n_chk++;
      if (bus.bus_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b exp 0", bus.bus_busy);
      end
   endtask

   task automatic test_single_read();
      logic [73:0] e;
      bus.rd_req = 2'b01;
      bus.req_addr[0] = 32'h0000_1234;
      #1;
      n_chk++;
      if (bus.bus_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_read_idle: got %b exp 0", bus.bus_busy);
      end
      for (int b = 0; b < BL; b++) begin
         tick();
         e = mk(2'b01, 2'b00, 1'b1, 1'b0, 32'h1220 + 32'(4 * b),
                32'h0, 3'(b), 1'b1);
         n_chk++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL single_read_beat%0d: got %h exp %h", b, outv(), e);
         end
         if (b == BL - 1) bus.rd_req = 2'b00;
      end
      tick();
      n_chk++;
      if (outv() !== '0) begin
         n_fail++;
         $display("FAIL single_read_end: got %h exp 0", outv());
      end
   endtask

   task automatic test_alternation();
      logic [31:0] base [NP];
      logic [73:0] e;
      int p;
      base[0] = 32'h0000_0100;
      base[1] = 32'h0000_2000;
      do_reset();
      bus.rd_req = 2'b11;
      bus.req_addr[0] = base[0];
      bus.req_addr[1] = base[1];
      for (int k = 0; k < 3; k++) begin
         p = k % 2;
         n_chk++;
         if (bus.bus_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL alt_gap%0d: got %b exp 0", k, bus.bus_busy);
         end
         for (int b = 0; b < BL; b++) begin
            tick();
            e = mk(2'(1 << p), 2'b00, 1'b1, 1'b0,
                   base[p] + 32'(4 * b), 32'h0, 3'(b), 1'b1);
            n_chk++;
            if (outv() !== e) begin
               n_fail++;
               $display("FAIL alt_burst%0d_beat%0d: got %h exp %h",
                        k, b, outv(), e);
            end
            if (k == 2 && b == BL - 1) bus.rd_req = 2'b00;
         end
         tick();
      end
      n_chk++;
      if (outv() !== '0) begin
         n_fail++;
         $display("FAIL alt_end: got %h exp 0", outv());
      end
   endtask

   task automatic test_write_priority();
      logic [73:0] e;
      do_reset();
      bus.rd_req = 2'b10;
      bus.wr_req = 2'b10;
      bus.req_addr[1] = 32'h0000_0040;
      bus.req_wr_data[1] = 32'hDEAD_BEEF;
      tick();
      e = mk(2'b00, 2'b10, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'd0, 1'b1);
      n_chk++;
      if (outv() !== e) begin
         n_fail++;
         $display("FAIL wr_beat: got %h exp %h", outv(), e);
      end
      bus.wr_req = 2'b00;
      tick();
      n_chk++;
      if (outv() !== '0) begin
         n_fail++;
         $display("FAIL wr_turnaround: got %h exp 0", outv());
      end
      for (int b = 0; b < BL; b++) begin
         tick();
         e = mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h40 + 32'(4 * b),
                32'h0, 3'(b), 1'b1);
         n_chk++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL wr_then_rd_beat%0d: got %h exp %h", b, outv(), e);
         end
         if (b == BL - 1) bus.rd_req = 2'b00;
      end
      tick();
      n_chk++;
      if (outv() !== '0) begin
         n_fail++;
         $display("FAIL wr_then_rd_end: got %h exp 0", outv());
      end
   endtask

   task automatic test_abort();
      logic [73:0] e;
      do_reset();
      bus.rd_req = 2'b11;
      bus.req_addr[0] = 32'h0000_1000;
      bus.req_addr[1] = 32'h0000_3000;
      for (int b = 0; b < 4; b++) begin
         tick();
         e = mk(2'b01, 2'b00, 1'b1, 1'b0, 32'h1000 + 32'(4 * b),
                32'h0, 3'(b), 1'b1);
         n_chk++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL abort_pre_beat%0d: got %h exp %h", b, outv(), e);
         end
      end
      bus.rd_req[0] = 1'b0;
      tick();
      n_chk++;
      if (outv() !== '0) begin
         n_fail++;
         $display("FAIL abort_idle: got %h exp 0", outv());
      end
      tick();
      e = mk(2'b10, 2'b00, 1'b1, 1'b0, 32'h3000, 32'h0, 3'd0, 1'b1);
      n_chk++;
      if (outv() !== e) begin
         n_fail++;
         $display("FAIL abort_next_port: got %h exp %h", outv(), e);
      end
      bus.rd_req = 2'b00;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [73:0] e;
      do_reset();
      bus.rd_req = 2'b01;
      bus.req_addr[0] = 32'h0000_5000;
      bus.req_addr[1] = 32'h0000_6000;
      for (int b = 0; b < 6; b++) tick();
      n_chk++;
      if (bus.beat_cnt !== 3'd5) begin
         n_fail++;
         $display("FAIL rstmid_beat5: got %0d exp 5", bus.beat_cnt);
      end
      rst_n = 1'b0;
      bus.rd_req = 2'b11;
      tick();
      n_chk++;
      if (outv() !== '0) begin
         n_fail++;
         $display("FAIL rstmid_clear: got %h exp 0", outv());
      end
      rst_n = 1'b1;
      tick();
      e = mk(2'b01, 2'b00, 1'b1, 1'b0, 32'h5000, 32'h0, 3'd0, 1'b1);
      n_chk++;
      if (outv() !== e) begin
         n_fail++;
         $display("FAIL rstmid_tie_port0: got %h exp %h", outv(), e);
      end
      bus.rd_req = 2'b00;
      tick();
   endtask

   task automatic test_random(input int ncyc);
      int             m_kind, m_beat, m_last, q;
      logic [PW-1:0]  m_port, pi;
      logic [31:0]    m_addr, m_data;
      logic [NP-1:0]  reqv, idle_at;
      logic [73:0]    e;
      int             wait_c [NP];
      int             beats [NP];
      bit             abrt [NP];
      bit             found;
      int             k;
      do_reset();
      // m_kind: 0 no transaction, 1 line read, 2 single write
      m_kind = 0;
      m_beat = 0;
      m_last = NP - 1;
      m_port = '0;
      m_addr = '0;
      m_data = '0;
      for (int p = 0; p < NP; p++) begin
         wait_c[p] = 0;
         beats[p] = 0;
         abrt[p] = 1'b0;
      end
      for (int c = 0; c < ncyc; c++) begin
         e = '0;
         if (m_kind == 1)
            e = mk(2'(1 << m_port), 2'b00, 1'b1, 1'b0,
                   {m_addr[31:5], 3'(m_beat), 2'b00}, 32'h0,
                   3'(m_beat), 1'b1);
         else if (m_kind == 2)
            e = mk(2'b00, 2'(1 << m_port), 1'b0, 1'b1,
                   m_addr, m_data, 3'd0, 1'b1);
         n_chk++;
         if (outv() !== e) begin
            n_fail++;
            $display("FAIL rand_cyc%0d: got %h exp %h", c, outv(), e);
         end
         n_chk++;
         if ($countones(bus.rd_granted | bus.wr_granted) > 1) begin
            n_fail++;
            $display("FAIL rand_onehot_cyc%0d: got %b/%b exp <=1 grant",
                     c, bus.rd_granted, bus.wr_granted);
         end
         for (int p = 0; p < NP; p++) begin
            pi = PW'(p);
            if ((bus.rd_req[pi] | bus.wr_req[pi]) &&
                !(bus.rd_granted[pi] | bus.wr_granted[pi])) begin
               wait_c[p]++;
               n_chk++;
               if (wait_c[p] > WAIT_MAX) begin
                  n_fail++;
                  $display("FAIL rand_wait_p%0d: got %0d cycles exp <=%0d",
                           p, wait_c[p], WAIT_MAX);
                  wait_c[p] = 0;
               end
            end else begin
               wait_c[p] = 0;
            end
            if (bus.rd_granted[pi] === 1'b1) begin
               beats[p]++;
            end else if (beats[p] != 0) begin
               if (!abrt[p]) begin
                  n_chk++;
                  if (beats[p] != BL) begin
                     n_fail++;
                     $display("FAIL rand_burst_len_p%0d: got %0d exp %0d",
                              p, beats[p], BL);
                  end
               end
               beats[p] = 0;
               abrt[p] = 1'b0;
            end
         end
         idle_at = ~(bus.rd_req | bus.wr_req);
         if (m_kind == 2) begin
            bus.wr_req[m_port] = 1'b0;
         end else if (m_kind == 1) begin
            if (m_beat == BL - 1) begin
               bus.rd_req[m_port] = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
               bus.rd_req[m_port] = 1'b0;
               abrt[m_port] = 1'b1;
            end
         end
         for (int p = 0; p < NP; p++) begin
            pi = PW'(p);
            if (idle_at[pi] && $urandom_range(0, 3) == 0) begin
               k = int'($urandom_range(0, 2));
               bus.rd_req[pi] = (k != 1);
               bus.wr_req[pi] = (k != 0);
               bus.req_addr[pi] = $urandom;
               bus.req_wr_data[pi] = $urandom;
            end
         end
         reqv = bus.rd_req | bus.wr_req;
         if (m_kind == 2) begin
            m_kind = 0;
         end else if (m_kind == 1) begin
            if (!bus.rd_req[m_port] || m_beat == BL - 1) begin
               m_kind = 0;
               m_beat = 0;
            end else begin
               m_beat++;
            end
         end else if (|reqv) begin
            found = 1'b0;
            for (int i = 1; i <= NP; i++) begin
               q = (m_last + i) % NP;
               if (!found && reqv[PW'(q)]) begin
                  m_port = PW'(q);
                  found = 1'b1;
               end
            end
            m_last = int'(m_port);
            m_kind = bus.wr_req[m_port] ? 2 : 1;
            m_beat = 0;
            m_addr = bus.req_addr[m_port];
            m_data = bus.req_wr_data[m_port];
         end
         tick();
      end
      bus.rd_req = '0;
      bus.wr_req = '0;
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rd_req = '0;
      bus.wr_req = '0;
      bus.req_addr = '0;
      bus.req_wr_data = '0;
      test_reset();
      test_single_read();
      test_alternation();
      test_write_priority();
      test_abort();
      test_reset_mid();
      test_random(10000);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
